mme_word_unpacker: RTL and testbench

- Sits directly downstream of the MME show-ahead FIFO.
- Pops DATA_WIDTH-bit words and serialises each into DATA_WIDTH/ELEM_WIDTH elements over a valid/ready stream toward the PE-array row input.
- One programmed burst (len_i words) per start_i; done_o pulses at completion.
- Back-to-back words stream with zero bubbles when the FIFO is non-empty.

---
 rtl/mme_word_unpacker.sv | 124 ++++++++++++
 tb/tb_mme_word_unpacker.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mme_word_unpacker.sv
// Word-to-element unpacker: pops FIFO words and streams them as ELEM_WIDTH lanes, LSB lane first.
// One burst of len_i words per start_i, with zero-bubble word reload when the FIFO stays non-empty.
module mme_word_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  elem_valid_o,
    input  logic                  elem_ready_i,
    output logic [ELEM_WIDTH-1:0] elem_data_o,
    output logic                  elem_last_o
);

    localparam int LANES  = DATA_WIDTH / ELEM_WIDTH;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

    logic last_lane;
    logic last_word;

    assign last_lane = (lane_q == LAST_LANE);
    // len_q is never zero outside IDLE/DONE, so len_q-1 cannot wrap where it matters
    assign last_word = (word_cnt_q == (len_q - CNT_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            lane_q     <= lane_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        lane_d       = lane_q;
        shreg_d      = shreg_q;
        fifo_rden_o  = 1'b0;
        elem_valid_o = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d      = len_i;
                    word_cnt_d = '0;
                    state_d    = (len_i != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (!fifo_empty_i) begin
                    fifo_rden_o = 1'b1;
                    shreg_d     = fifo_rdata_i;
                    lane_d      = '0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                elem_valid_o = 1'b1;
                if (elem_ready_i) begin
                    if (last_lane) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        if (last_word) begin
                            state_d = S_DONE;
                        end else if (!fifo_empty_i) begin
                            // Reload in the same cycle as the final lane handshake
                            fifo_rden_o = 1'b1;
                            shreg_d     = fifo_rdata_i;
                            lane_d      = '0;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        shreg_d = shreg_q >> ELEM_WIDTH;
                        lane_d  = lane_q + LANE_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign elem_data_o = (state_q == S_SHIFT) ? shreg_q[ELEM_WIDTH-1:0] : '0;
    assign elem_last_o = (state_q == S_SHIFT) && last_lane && last_word;

endmodule

// File: tb/tb_mme_word_unpacker.sv
// Directed bench for mme_word_unpacker: a small FIFO model feeds bursts and per-cycle outputs are recorded.
module tb_mme_word_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o;
    logic        fifo_empty_i, fifo_rden_o;
    logic [31:0] fifo_rdata_i;
    logic        elem_valid_o;
    logic        elem_ready_i = 1'b0;
    logic [7:0]  elem_data_o;
    logic        elem_last_o;

    mme_word_unpacker #(.DATA_WIDTH(32), .ELEM_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .fifo_empty_i(fifo_empty_i), .fifo_rden_o(fifo_rden_o), .fifo_rdata_i(fifo_rdata_i),
        .elem_valid_o(elem_valid_o), .elem_ready_i(elem_ready_i),
        .elem_data_o(elem_data_o), .elem_last_o(elem_last_o)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [31:0] mem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_cnt = 0;
    logic        flush = 1'b0;
    logic        underflow = 1'b0;
    logic [3:0]  rd_idx;

    assign rd_idx       = rd_ptr[3:0];
    assign fifo_empty_i = (rd_ptr == wr_ptr);
    assign fifo_rdata_i = mem[rd_idx];

    always @(posedge clk) begin
        if (fifo_rden_o && fifo_empty_i) underflow <= 1'b1;
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rden_o && !fifo_empty_i) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    logic       obs_valid [32];
    logic       obs_rdy   [32];
    logic       obs_last  [32];
    logic       obs_rden  [32];
    logic       obs_done  [32];
    logic       obs_busy  [32];
    logic [7:0] obs_data  [32];
    logic [7:0] got [16];
    int         ngot;
    int         p0;

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush_fifo();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Cycle 0 carries the start pulse; every cycle is recorded 1 time unit after the falling edge.
    task automatic run(input int ncyc, input logic [15:0] len, input int start2_c, input int push_c,
                       input logic [31:0] pw1, input logic [31:0] pw2, input int rdy_mode, input int rst_c);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start_i      = (c == 0) || (c == start2_c);
            len_i        = (c == 0) ? len : 16'd5;
            rst          = (c == rst_c);
            elem_ready_i = (rdy_mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (c == push_c) begin
                push(pw1);
                push(pw2);
            end
            #1;
            obs_valid[c] = elem_valid_o;
            obs_rdy[c]   = elem_ready_i;
            obs_last[c]  = elem_last_o;
            obs_rden[c]  = fifo_rden_o;
            obs_done[c]  = done_o;
            obs_busy[c]  = busy_o;
            obs_data[c]  = elem_data_o;
        end
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic collect(input int ncyc);
        ngot = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (obs_valid[c] && obs_rdy[c] && ngot < 16) begin
                got[ngot] = obs_data[c];
                ngot++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, fifo_rden_o, elem_valid_o, elem_last_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy_o, done_o, fifo_rden_o, elem_valid_o, elem_last_o});
        end
        checks++;
        if (elem_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", elem_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nrd;
        push(32'h44332211);
        push(32'h88776655);
        p0 = pop_cnt;
        run(12, 16'd2, -1, -1, 32'h0, 32'h0, 0, -1);
        checks++;
        if (obs_busy[0] !== 1'b0 || obs_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b%b exp=01", obs_busy[0], obs_busy[1]);
        end
        checks++;
        if (obs_rden[1] !== 1'b1 || obs_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL basic_fetch got=rden%b/valid%b exp=rden1/valid0", obs_rden[1], obs_valid[1]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_valid[k+2] !== 1'b1 || obs_data[k+2] !== 8'(8'h11 * (k + 1))) begin
                failures++;
                $display("FAIL basic_elem%0d got=%b/%h exp=1/%h", k, obs_valid[k+2], obs_data[k+2], 8'(8'h11 * (k + 1)));
            end
            checks++;
            if (obs_last[k+2] !== (k == 7)) begin
                failures++;
                $display("FAIL basic_last%0d got=%b exp=%b", k, obs_last[k+2], (k == 7));
            end
        end
        nrd = 0;
        for (int c = 0; c < 12; c++) nrd += int'(obs_rden[c]);
        checks++;
        if (obs_rden[5] !== 1'b1 || nrd != 2) begin
            failures++;
            $display("FAIL basic_rden got=c5:%b total:%0d exp=c5:1 total:2", obs_rden[5], nrd);
        end
        checks++;
        if (obs_done[10] !== 1'b1 || obs_done[9] !== 1'b0 || obs_done[11] !== 1'b0 || obs_busy[11] !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got=%b%b%b busy11=%b exp=010 busy11=0", obs_done[9], obs_done[10], obs_done[11], obs_busy[11]);
        end
        checks++;
        if (pop_cnt - p0 != 2) begin
            failures++;
            $display("FAIL basic_pops got=%0d exp=2", pop_cnt - p0);
        end
    endtask

    task automatic test_stall();
        int ndone;
        int bad_hold;
        push(32'h44332211);
        push(32'h88776655);
        p0 = pop_cnt;
        run(30, 16'd2, -1, -1, 32'h0, 32'h0, 1, -1);
        collect(30);
        checks++;
        if (ngot != 8) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=8", ngot);
        end
        for (int k = 0; k < 8 && k < ngot; k++) begin
            checks++;
            if (got[k] !== 8'(8'h11 * (k + 1))) begin
                failures++;
                $display("FAIL stall_elem%0d got=%h exp=%h", k, got[k], 8'(8'h11 * (k + 1)));
            end
        end
        bad_hold = 0;
        ndone = 0;
        for (int c = 0; c < 29; c++) begin
            if (obs_valid[c] && !obs_rdy[c] &&
                (obs_valid[c+1] !== 1'b1 || obs_data[c+1] !== obs_data[c] || obs_last[c+1] !== obs_last[c]))
                bad_hold++;
            ndone += int'(obs_done[c]);
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d unstable cycles exp=0", bad_hold);
        end
        checks++;
        if (ndone != 1 || obs_done[25] !== 1'b1) begin
            failures++;
            $display("FAIL stall_done got=%0d pulses c25=%b exp=1 pulse c25=1", ndone, obs_done[25]);
        end
        checks++;
        if (pop_cnt - p0 != 2) begin
            failures++;
            $display("FAIL stall_pops got=%0d exp=2", pop_cnt - p0);
        end
    endtask

    task automatic test_gap();
        int ndone;
        push(32'h04030201);
        p0 = pop_cnt;
        run(24, 16'd3, -1, 8, 32'h08070605, 32'h0C0B0A09, 0, -1);
        checks++;
        if (obs_rden[6] !== 1'b0 || obs_valid[6] !== 1'b0 || obs_rden[7] !== 1'b0 ||
            obs_valid[7] !== 1'b0 || obs_busy[7] !== 1'b1) begin
            failures++;
            $display("FAIL gap_wait got=rden%b%b valid%b%b exp=rden00 valid00", obs_rden[6], obs_rden[7], obs_valid[6], obs_valid[7]);
        end
        checks++;
        if (obs_rden[8] !== 1'b1 || obs_valid[9] !== 1'b1 || obs_data[9] !== 8'h05) begin
            failures++;
            $display("FAIL gap_resume got=rden%b valid%b data%h exp=rden1 valid1 data05", obs_rden[8], obs_valid[9], obs_data[9]);
        end
        collect(24);
        checks++;
        if (ngot != 12) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=12", ngot);
        end
        for (int k = 0; k < 12 && k < ngot; k++) begin
            checks++;
            if (got[k] !== 8'(k + 1)) begin
                failures++;
                $display("FAIL gap_elem%0d got=%h exp=%h", k, got[k], 8'(k + 1));
            end
        end
        ndone = 0;
        for (int c = 0; c < 24; c++) ndone += int'(obs_done[c]);
        checks++;
        if (ndone != 1 || obs_done[17] !== 1'b1 || obs_last[16] !== 1'b1) begin
            failures++;
            $display("FAIL gap_done got=%0d pulses c17=%b last16=%b exp=1 pulse c17=1 last16=1", ndone, obs_done[17], obs_last[16]);
        end
        checks++;
        if (pop_cnt - p0 != 3) begin
            failures++;
            $display("FAIL gap_pops got=%0d exp=3", pop_cnt - p0);
        end
    endtask

    task automatic test_len_zero();
        int nact;
        push(32'hDEADBEEF);
        run(4, 16'd0, -1, -1, 32'h0, 32'h0, 0, -1);
        checks++;
        if (obs_done[1] !== 1'b1 || obs_busy[1] !== 1'b1 || obs_done[2] !== 1'b0 || obs_busy[2] !== 1'b0) begin
            failures++;
            $display("FAIL len0_done got=done%b%b busy%b%b exp=done10 busy10", obs_done[1], obs_done[2], obs_busy[1], obs_busy[2]);
        end
        nact = 0;
        for (int c = 0; c < 4; c++) nact += int'(obs_rden[c]) + int'(obs_valid[c]);
        checks++;
        if (nact != 0) begin
            failures++;
            $display("FAIL len0_quiet got=%0d rden/valid cycles exp=0", nact);
        end
        flush_fifo();
    endtask

    task automatic test_mid_reset();
        push(32'h44332211);
        push(32'h88776655);
        p0 = pop_cnt;
        run(8, 16'd2, -1, -1, 32'h0, 32'h0, 0, 4);
        checks++;
        if (obs_data[3] !== 8'h22 || obs_valid[3] !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got=%h exp=22", obs_data[3]);
        end
        checks++;
        if ({obs_busy[5], obs_done[5], obs_rden[5], obs_valid[5], obs_last[5]} !== 5'b0 || obs_data[5] !== 8'h00) begin
            failures++;
            $display("FAIL rst_post got=%b data=%h exp=00000 data=00",
                     {obs_busy[5], obs_done[5], obs_rden[5], obs_valid[5], obs_last[5]}, obs_data[5]);
        end
        checks++;
        if (pop_cnt - p0 != 1) begin
            failures++;
            $display("FAIL rst_pops got=%0d exp=1", pop_cnt - p0);
        end
        flush_fifo();
        push(32'hDDCCBBAA);
        run(8, 16'd1, -1, -1, 32'h0, 32'h0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_valid[k+2] !== 1'b1 || obs_data[k+2] !== 8'(8'hAA + 8'h11 * k) || obs_last[k+2] !== (k == 3)) begin
                failures++;
                $display("FAIL rst_fresh%0d got=%b/%h/%b exp=1/%h/%b", k, obs_valid[k+2], obs_data[k+2], obs_last[k+2],
                         8'(8'hAA + 8'h11 * k), (k == 3));
            end
        end
        checks++;
        if (obs_done[6] !== 1'b1) begin
            failures++;
            $display("FAIL rst_fresh_done got=%b exp=1", obs_done[6]);
        end
    endtask

    task automatic test_ignored_start();
        int ndone;
        int nvalid;
        push(32'h44332211);
        push(32'h88776655);
        p0 = pop_cnt;
        run(16, 16'd2, 4, -1, 32'h0, 32'h0, 0, -1);
        collect(16);
        checks++;
        if (ngot != 8 || got[7] !== 8'h88) begin
            failures++;
            $display("FAIL ign_count got=%0d last=%h exp=8 last=88", ngot, got[7]);
        end
        ndone = 0;
        nvalid = 0;
        for (int c = 0; c < 16; c++) begin
            ndone += int'(obs_done[c]);
            if (c > 10) nvalid += int'(obs_valid[c]) + int'(obs_busy[c]);
        end
        checks++;
        if (ndone != 1 || obs_done[10] !== 1'b1 || nvalid != 0) begin
            failures++;
            $display("FAIL ign_done got=%0d pulses c10=%b after=%0d exp=1 pulse c10=1 after=0", ndone, obs_done[10], nvalid);
        end
        checks++;
        if (pop_cnt - p0 != 2) begin
            failures++;
            $display("FAIL ign_pops got=%0d exp=2", pop_cnt - p0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_len_zero();
        test_mid_reset();
        test_ignored_start();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow got=%b exp=0", underflow);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
